// File: rtl/wide_add_sequencer_if.sv
// Requester-side bundle for the wide add/subtract sequencer.
interface wide_add_sequencer_if #(
   parameter int WORDS = 4
);
   logic                  start;
   logic                  sub;
   logic [32*WORDS-1:0]   a;
   logic [32*WORDS-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [32*WORDS-1:0]   result;
   logic                  cout;
   logic                  ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, cout, ovf
   );
endinterface

// File: rtl/wide_add_sequencer.sv
// 32*WORDS-bit add/sub built from one 32-bit CLA, one word per clock,
// least-significant word first with the carry held between words.
module addthirtytwobit (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_cout
);
   always_comb begin
      logic [31:0] g;
      logic [31:0] p;
      logic [32:0] c;
      logic [7:0]  gg;
      logic [7:0]  gp;
      g  = i_a & i_b;
      p  = i_a ^ i_b;
      c  = '0;
      gg = '0;
      gp = '0;
      for (int j = 0; j < 8; j++) begin
         gp[j] = &p[4*j +: 4];
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (&p[4*j+1 +: 3] & g[4*j]);
      end
      c[0] = i_cin;
      // group carries look ahead; bits inside a nibble ripple
      for (int j = 0; j < 8; j++) begin
         c[4*j+4] = gg[j] | (gp[j] & c[4*j]);
         for (int k = 1; k < 4; k++)
            c[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & c[4*j+k-1]);
      end
      o_sum  = p ^ c[31:0];
      o_cout = c[32];
   end
endmodule

module wide_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   wide_add_sequencer_if.slave  bus
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int N  = 32 * WORDS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic            r_sub;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_result;
   logic            r_cout;
   logic            r_ovf;

   logic            w_accept;
   logic            w_last;
   logic [31:0]     w_aw;
   logic [31:0]     w_bw;
   logic [31:0]     w_sum;
   logic            w_co;

   assign w_accept = bus.start && (r_state != S_RUN);
   assign w_last   = (r_idx == IW'(WORDS - 1));
   assign w_aw     = r_a[32*r_idx +: 32];
   assign w_bw     = r_b[32*r_idx +: 32] ^ {32{r_sub}};

   addthirtytwobit u_add (
      .i_a    (w_aw),
      .i_b    (w_bw),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_next = S_RUN;
         S_RUN:   if (w_last)    w_next = S_DONE;
         S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_sub    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_sub   <= bus.sub;
         r_idx   <= '0;
         r_carry <= bus.sub;
      end else if (r_state == S_RUN) begin
         r_result[32*r_idx +: 32] <= w_sum;
         r_carry <= w_co;
         if (w_last) begin
            r_cout <= w_co;
            // carry into bit 31 xor carry out of bit 31
            r_ovf  <= (w_aw[31] ^ w_bw[31] ^ w_sum[31]) ^ w_co;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign bus.busy   = (r_state == S_RUN);
   assign bus.done   = (r_state == S_DONE);
   assign bus.result = r_result;
   assign bus.cout   = r_cout;
   assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer against a 129-bit arithmetic model.
module tb_wide_add_sequencer;
   localparam int W = 4;
   localparam int N = 32 * W;

   typedef struct {
      logic [N-1:0] r;
      logic         c;
      logic         o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wide_add_sequencer_if #(.WORDS(W)) bus ();

   wide_add_sequencer #(.WORDS(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];
   int   done_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [N-1:0] got, logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic fail(string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] b, logic s);
      logic [N:0]   t;
      logic [N-1:0] bb;
      exp_t         e;
      bb  = s ? ~b : b;
      t   = {1'b0, a} + {1'b0, bb} + (N+1)'(s);
      e.r = t[N-1:0];
      e.c = t[N];
      if (s) e.o = (a[N-1] != b[N-1]) && (e.r[N-1] != a[N-1]);
      else   e.o = (a[N-1] == b[N-1]) && (e.r[N-1] != a[N-1]);
      return e;
   endfunction

   function automatic exp_t mk(logic [N-1:0] r, logic c, logic o);
      exp_t e;
      e.r = r;
      e.c = c;
      e.o = o;
      return e;
   endfunction

   // monitor: pops scoreboard on every done pulse
   initial begin
      int   run;
      logic pdone;
      exp_t e;
      run   = 0;
      pdone = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            run   = 0;
            pdone = 1'b0;
         end else begin
            if (bus.busy && bus.done) fail("busy_and_done");
            if (bus.done && pdone) fail("done_two_cycles");
            if (bus.busy) run++;
            if (bus.done) begin
               chk("busy_len", N'(run), N'(W));
               run = 0;
               done_cyc.push_back(cyc);
               if (sb.size() == 0) begin
                  fail("unexpected_done");
               end else begin
                  e = sb.pop_front();
                  chk("result", bus.result, e.r);
                  chk("cout", N'(bus.cout), N'(e.c));
                  chk("ovf", N'(bus.ovf), N'(e.o));
               end
            end
            pdone = bus.done;
         end
      end
   end

   task automatic issue(logic [N-1:0] a, logic [N-1:0] b, logic s, exp_t e);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) fail("issue_timeout");
      bus.a     = a;
      bus.b     = b;
      bus.sub   = s;
      bus.start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) fail("drain_timeout");
      @(negedge clk);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_busy"}, N'(bus.busy), '0);
      chk({tag, "_done"}, N'(bus.done), '0);
      chk({tag, "_result"}, bus.result, '0);
      chk({tag, "_cout"}, N'(bus.cout), '0);
      chk({tag, "_ovf"}, N'(bus.ovf), '0);
   endtask

   localparam logic [N-1:0] ONES = {N{1'b1}};
   localparam logic [N-1:0] ONE  = N'(1);
   localparam logic [N-1:0] MSB  = {1'b1, {(N-1){1'b0}}};

   initial begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         s;
      int           n;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      issue({32'h0, {96{1'b1}}}, ONE, 1'b0,
            mk({32'h1, 96'h0}, 1'b0, 1'b0));
      drain();
      issue(ONES, ONE, 1'b0, mk('0, 1'b1, 1'b0));
      drain();
      issue(~MSB, ONE, 1'b0, mk(MSB, 1'b0, 1'b1));
      drain();
      issue('0, ONE, 1'b1, mk(ONES, 1'b0, 1'b0));
      drain();
      issue(MSB, ONE, 1'b1, mk(~MSB, 1'b1, 1'b1));
      drain();

      // start pulse during RUN must be ignored
      issue({4{32'h1234_5678}}, {4{32'h1111_1111}}, 1'b0,
            mk({4{32'h2345_6789}}, 1'b0, 1'b0));
      @(negedge clk);
      bus.a     = ONES;
      bus.b     = ONES;
      bus.sub   = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      drain();

      // back-to-back via start held into the DONE cycle
      done_cyc.delete();
      @(negedge clk);
      bus.a     = {4{32'hAAAA_AAAA}};
      bus.b     = {4{32'h5555_5555}};
      bus.sub   = 1'b0;
      bus.start = 1'b1;
      sb.push_back(mk(ONES, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      bus.a   = N'(10);
      bus.b   = N'(3);
      bus.sub = 1'b1;
      sb.push_back(mk(N'(7), 1'b1, 1'b0));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 20);
      if (!bus.done) fail("b2b_first_done");
      @(posedge clk);
      #1 bus.start = 1'b0;
      drain();
      if (done_cyc.size() == 2)
         chk("b2b_spacing", N'(done_cyc[1] - done_cyc[0]), N'(W + 1));
      else
         fail("b2b_done_count");

      // asynchronous reset in the middle of RUN
      issue({4{32'hDEAD_BEEF}}, {4{32'h0101_0101}}, 1'b0,
            mk('0, 1'b0, 1'b0));
      @(posedge clk);
      #2;
      chk("pre_reset_busy", N'(bus.busy), N'(1));
      rst = 1'b1;
      #1;
      sb.delete();
      chk_zero("midrun_reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      issue(N'(5), N'(9), 1'b1, model(N'(5), N'(9), 1'b1));
      drain();

      for (int i = 0; i < 1000; i++) begin
         a = {$urandom, $urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom};
         s = 1'($urandom);
         case ($urandom_range(0, 7))
            0: b = ~a;
            1: b = a;
            2: a = ONES;
            3: b = MSB;
            default: ;
         endcase
         issue(a, b, s, model(a, b, s));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      drain();
      chk("sb_empty", N'(sb.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word add/subtract sequencer that time-shares a single `addthirtytwobit` 32-bit carry-lookahead adder to perform 32·WORDS-bit operations, one 32-bit word per clock, least-significant word first. The carry is held in a register between words. It sits between a wide-operand requester (start/done handshake) and the shared 32-bit adder datapath. It is the standard way the design performs additions wider than 32 bits.

## Interface
Parameters:
- WORDS, default 4: number of 32-bit words per operand. Legal values are ≥ 2. Operand width is 32·WORDS.

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only when state is IDLE or DONE
- sub  in  1  0 = a+b, 1 = a−b; latched with start
- a  in  32·WORDS  operand A; latched with start
- b  in  32·WORDS  operand B; latched with start
- busy  out  1  high while a word is being processed (RUN)
- done  out  1  one-cycle pulse: result, cout and ovf are final
- result  out  32·WORDS  registered sum or difference
- cout  out  1  final carry out; for subtract, 1 means no borrow (a ≥ b unsigned)
- ovf  out  1  signed two's-complement overflow of the full-width operation

## Operation
- One `addthirtytwobit` instance is used. Per cycle its inputs are:
  - a_word = A_lat[32i+31:32i]
  - b_word = B_lat[32i+31:32i] XOR {32{sub_lat}}
  - cin = carry_reg
- Internal state: state ∈ {IDLE, RUN, DONE}, index i (0..WORDS−1, ⌈log2 WORDS⌉ bits), carry_reg, A_lat, B_lat, sub_lat.
- IDLE: if start=1, latch a, b and sub; set i←0, carry_reg←sub; go to RUN. Otherwise stay in IDLE.
- RUN, every cycle:
  - result[32i+31:32i] ← adder sum
  - carry_reg ← adder cout
  - If i = WORDS−1:
    - cout ← adder cout
    - ovf ← (A_lat[MSB] ^ b_word[31] ^ sum[31]) ^ adder cout
    - go to DONE
  - Otherwise i ← i+1.
- RUN ignores start.
- DONE: done=1 for exactly this cycle.
  - If start=1, latch new operands and go directly to RUN (back-to-back, no IDLE bubble).
  - Otherwise go to IDLE.
- result, cout and ovf hold their values in IDLE and DONE.
- During RUN, result words are overwritten progressively. result is valid only from done until the next accepted start.
- Arithmetic is modulo 2^(32·WORDS). Subtract is a + ~b + 1, with the +1 supplied as the initial carry.
- The index never wraps inside RUN. The transition to DONE happens at i = WORDS−1.

## Timing
- Reset (rst=1, asynchronous, effective immediately regardless of clk):
  - state=IDLE, i=0, carry_reg=0
  - busy=0, done=0, result=0, cout=0, ovf=0
- Reset asserted mid-RUN aborts the operation: no done pulse, and partial results are cleared to 0. The first start is accepted at the first rising edge after rst deasserts.
- start accepted at edge E0:
  - busy=1 from E0 to E_WORDS
  - word k is registered at edge E(k+1)
  - done=1 from E_WORDS to E_(WORDS+1)
  - Latency is WORDS+1 cycles from the accepting edge to the done edge window.
- busy and done are never high in the same cycle.
- Throughput with back-to-back starts: one operation every WORDS+1 cycles.
- start held high continuously: a new operation is accepted in every DONE cycle.
- Operand inputs are don't-care except at the accepting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WORDS=4.
- Reset: apply rst during RUN with operands nonzero → all outputs 0 immediately, state IDLE, no done pulse; a subsequent start completes normally.
- Carry across words: a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1, sub=0 → result=0x00000001_00000000_00000000_00000000, cout=0, ovf=0; busy high for exactly 4 cycles, done exactly 1 cycle later.
- Wrap and signed overflow:
  - a=all ones, b=1 → result=0, cout=1, ovf=0
  - a=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1 → result=0x80000000_00000000_00000000_00000000, cout=0, ovf=1
- Subtract:
  - a=0, b=1, sub=1 → result=all ones, cout=0 (borrow), ovf=0
  - a=0x80000000_00000000_00000000_00000000, b=1, sub=1 → result=0x7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, cout=1, ovf=1
- Handshake:
  - start pulsed during RUN with different operands → ignored; result matches the first operation
  - start asserted in the DONE cycle → new operation begins next cycle; two done pulses spaced exactly 5 cycles apart, both results correct
- Randomized regression: 1000 random a, b and sub values compared against a 128-bit reference model for result, cout and ovf.
